gray_position_sequencer: RTL

- Command-driven controller that sequences an up/down Gray-code position counter toward a requested target, one Gray step at a time.
- Picks the shortest direction around the ring and paces steps with a programmable divider.
- Reports busy, per-step and completion status.
- Sits between a host/command source and any consumer of a Gray-coded position, such as an encoder emulator or a CDC pointer.

---
 rtl/gray_position_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gray_position_sequencer.sv
// Command-driven Gray-code position sequencer: steps a ring position toward a
// requested target by the shortest direction, one Gray step every STEP_DIV cycles.
module gray_position_sequencer #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned STEP_DIV = 2
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] pos_bin,
    output logic             dir,
    output logic             step,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0] HALF_RING  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pos_q, pos_d;
    logic [WIDTH-1:0]   tgt_q, tgt_d;
    logic [WIDTH-1:0]   gray_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;
    logic               ready_q, busy_q, done_q;
    logic [WIDTH-1:0]   diff;

    // Next-state, position and pacing logic
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        dir_d   = dir_q;
        div_d   = div_q;
        step_d  = 1'b0;
        diff    = WIDTH'(cmd_target - pos_q);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_d = cmd_target;
                    div_d = DIV_RELOAD;
                    if (diff == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        // Exact half-ring tie resolves forward
                        dir_d   = (diff > HALF_RING);
                        state_d = ST_MOVE;
                    end
                end
            end
            ST_MOVE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    if (div_q != '0) begin
                        div_d = div_q - DIV_W'(1);
                    end else begin
                        div_d  = DIV_RELOAD;
                        pos_d  = dir_q ? (pos_q - WIDTH'(1)) : (pos_q + WIDTH'(1));
                        step_d = 1'b1;
                        if (pos_d == tgt_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            gray_q  <= '0;
            div_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            gray_q  <= pos_d ^ (pos_d >> 1);
            div_q   <= div_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d == ST_MOVE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign cmd_ready = ready_q;
    assign gray_out  = gray_q;
    assign pos_bin   = pos_q;
    assign dir       = dir_q;
    assign step      = step_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
